crop_frame_ctrl: RTL and testbench
==================================

# crop_frame_ctrl

Frame-level sequencer for the capture crop path. On a start request it waits for a frame boundary and measures one full frame. During that frame it builds the bounding box (XSTART/XEND/YSTART/YEND) of all pixels at or above a threshold. On the following frame it gates the pixel stream so only pixels inside that box leave with valid and coordinates. It sits between the sensor pixel stream (640x480, 10-bit) and the downstream capture/store logic, and owns the crop window registers.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- iCLK  in  1  pixel clock, all logic on rising edge
- iRST  in  1  asynchronous, active-low reset
- iSTART  in  1  one-cycle request to run a measure+crop sequence
- iTHRESH  in  10  qualify threshold, latched when iSTART is accepted
- iDVAL  in  1  input pixel valid
- iDATA  in  10  input pixel value
- oBUSY  out  1  high in ARM, MEASURE, CROP
- oDONE  out  1  one-cycle pulse at sequence end
- oNOTFOUND  out  1  one-cycle pulse with oDONE when no pixel qualified
- oXSTART, oXEND, oYSTART, oYEND  out  16 each  latched crop box
- oDVAL  out  1  cropped pixel valid
- oDATA  out  10  cropped pixel value
- oX_Cont, oY_Cont  out  16 each  coordinates of the pixel on oDATA

## Operation
- Position counters X (0..H_ACTIVE-1) and Y (0..V_ACTIVE-1) run from reset in every state. They advance only on iDVAL beats. X wraps to 0 and increments Y. At (H_ACTIVE-1, V_ACTIVE-1) both wrap to 0. Counters are 16-bit; coordinates are zero-extended.
- A pixel qualifies when iDVAL=1 and iDATA >= latched threshold. Equal qualifies.
- States:
  - IDLE: iSTART=1 latches iTHRESH and moves to ARM.
  - ARM: the first iDVAL beat at (0,0) is processed as a MEASURE beat, and the state becomes MEASURE.
  - MEASURE: tracks min/max X and Y of qualifying pixels plus a found flag. The (0,0) beat in ARM initialises min/max directly, with no stale compare. The beat at (H_ACTIVE-1, V_ACTIVE-1) is the last one processed. After it:
    - If found: the box registers load from min/max and the state moves to CROP.
    - If not found: the box registers keep their old values, oDONE and oNOTFOUND pulse, and the state returns to IDLE.
  - CROP: an iDVAL beat with XSTART <= X <= XEND and YSTART <= Y <= YEND produces oDVAL=1 with oDATA=iDATA and oX_Cont/oY_Cont = X/Y. Bounds are inclusive. After the beat at (H_ACTIVE-1, V_ACTIVE-1), oDONE pulses and the state returns to IDLE.
- iSTART while oBUSY=1 is ignored, with no queuing.
- The box registers hold until the next successful MEASURE or reset.

## Timing
- Reset (async assert, sync release): every output is 0, counters are 0, state is IDLE, and the latched threshold is 0.
- oDVAL, oDATA, oX_Cont and oY_Cont are registered: 1-cycle latency after the iDVAL beat. oDVAL=0 outside CROP and on non-window beats. oDATA/oX_Cont/oY_Cont hold their last value when oDVAL=0.
- oBUSY rises the cycle after iSTART is accepted.
- oBUSY falls on the same cycle as the oDONE pulse.
- oDONE/oNOTFOUND (measure-fail) are asserted the cycle after the last MEASURE beat.
- oDONE (crop) is asserted the cycle after the last CROP beat, coincident with that beat's oDVAL if it was in-window.
- Box registers update the cycle after the last MEASURE beat, so they are stable before the first CROP beat.
- Gaps in iDVAL stall counters and states; no timeout.
- iSTART in the same cycle oDONE is high: the state is still busy internally, so it is ignored. IDLE accepts from the next cycle.
- Reset mid-sequence: outputs clear immediately. The next iSTART performs a full ARM wait.

## Test plan
- Use H_ACTIVE=8 and V_ACTIVE=4 for all scenarios.
- Reset: hold iRST=0 with iDVAL toggling -> all outputs 0 and counters stay at 0. After release, counters step only on iDVAL beats.
- Single bright pixel: thresh=512, pixel (3,2)=900, all others 100 -> box 3/3/2/2. The crop frame gives exactly one oDVAL, with oDATA=900 and oX_Cont=3, oY_Cont=2. There is one oDONE pulse, oNOTFOUND=0, and oBUSY spans about 2 frames after the ARM wait.
- Rectangle plus threshold edge: pixels at X 2..5, Y 1..2 = 512 (equal to thresh) -> box XSTART=2, XEND=5, YSTART=1, YEND=2. The crop frame gives 8 oDVAL beats in raster order.
- No qualifying pixel: all data=10, thresh=512 -> oDONE and oNOTFOUND pulse together one cycle after the (7,3) beat of the measure frame. There are no oDVAL beats, the box keeps its previous values, and the state returns to IDLE.
- Stream gaps and mid-frame start: iDVAL randomly deasserted 50%, and iSTART issued at counter (4,1) -> MEASURE starts at the next (0,0). The box and crop output match the gap-free run.
- Reset during CROP, and iSTART while busy: a second iSTART during MEASURE is ignored (one oDONE only). iRST=0 for 1 cycle mid-CROP -> oDVAL=0, box=0 and oBUSY=0 immediately. A new iSTART then completes a normal sequence.

Source files
------------

// File: rtl/crop_frame_ctrl.sv
// crop_frame_ctrl
//   Frame-level sequencer for the capture crop path. A start request arms the
//   block. It then waits for the next frame origin and measures one frame,
//   building the bounding box of every pixel at or above the latched
//   threshold. On the frame after that, it passes only the pixels inside the
//   box.
//
// Ports
//   iCLK, iRST             pixel clock, async active-low reset
//   iSTART, iTHRESH        sequence request + threshold (latched on accept)
//   iDVAL, iDATA           sensor pixel stream
//   oBUSY                  sequence in progress (ARM/MEASURE/CROP)
//   oDONE, oNOTFOUND       end-of-sequence pulse / empty-box flag
//   oXSTART..oYEND         latched crop box
//   oDVAL, oDATA           cropped pixel stream (1-cycle latency)
//   oX_Cont, oY_Cont       coordinates of the pixel on oDATA
module crop_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [9:0]  iTHRESH,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oNOTFOUND,
    output logic [15:0] oXSTART,
    output logic [15:0] oXEND,
    output logic [15:0] oYSTART,
    output logic [15:0] oYEND,
    output logic        oDVAL,
    output logic [9:0]  oDATA,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_CROP} state_t;

    state_t      state_q;
    logic [15:0] x_q, y_q;
    logic [9:0]  thresh_q;
    logic        found_q, found_d;
    logic [15:0] minx_q, maxx_q, miny_q, maxy_q;
    logic [15:0] minx_d, maxx_d, miny_d, maxy_d;
    logic [15:0] xs_q, xe_q, ys_q, ye_q;
    logic        busy_q, done_q, nf_q, odval_q;
    logic [9:0]  odata_q;
    logic [15:0] ox_q, oy_q;

    logic x_end, y_end, origin, last_px, qual, in_win;

    assign x_end   = (x_q == 16'(H_ACTIVE - 1));
    assign y_end   = (y_q == 16'(V_ACTIVE - 1));
    assign origin  = iDVAL && (x_q == 16'd0) && (y_q == 16'd0);
    assign last_px = iDVAL && x_end && y_end;
    assign qual    = iDVAL && (iDATA >= thresh_q);
    assign in_win  = (x_q >= xs_q) && (x_q <= xe_q) && (y_q >= ys_q) && (y_q <= ye_q);

    // Min/max tracker. The origin beat (taken in ARM) seeds the trackers
    // directly so nothing from a previous sequence leaks into the compare.
    always_comb begin
        found_d = found_q;
        minx_d  = minx_q;
        maxx_d  = maxx_q;
        miny_d  = miny_q;
        maxy_d  = maxy_q;
        if (state_q == S_ARM) begin
            found_d = qual;
            minx_d  = x_q;
            maxx_d  = x_q;
            miny_d  = y_q;
            maxy_d  = y_q;
        end else if (qual) begin
            if (!found_q) begin
                found_d = 1'b1;
                minx_d  = x_q;
                maxx_d  = x_q;
                miny_d  = y_q;
                maxy_d  = y_q;
            end else begin
                if (x_q < minx_q) minx_d = x_q;
                if (x_q > maxx_q) maxx_d = x_q;
                if (y_q < miny_q) miny_d = y_q;
                if (y_q > maxy_q) maxy_d = y_q;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            thresh_q <= '0;
            found_q  <= 1'b0;
            minx_q   <= '0;
            maxx_q   <= '0;
            miny_q   <= '0;
            maxy_q   <= '0;
            xs_q     <= '0;
            xe_q     <= '0;
            ys_q     <= '0;
            ye_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nf_q     <= 1'b0;
            odval_q  <= 1'b0;
            odata_q  <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            nf_q    <= 1'b0;
            odval_q <= 1'b0;

            // Raster position runs in every state, stepping only on beats.
            if (iDVAL) begin
                if (x_end) begin
                    x_q <= '0;
                    y_q <= y_end ? 16'd0 : y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    // done_q high means the sequence only just ended; the
                    // request is dropped rather than chaining a new run.
                    if (iSTART && !done_q) begin
                        thresh_q <= iTHRESH;
                        busy_q   <= 1'b1;
                        state_q  <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (origin) begin
                        found_q <= found_d;
                        minx_q  <= minx_d;
                        maxx_q  <= maxx_d;
                        miny_q  <= miny_d;
                        maxy_q  <= maxy_d;
                        state_q <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (iDVAL) begin
                        found_q <= found_d;
                        minx_q  <= minx_d;
                        maxx_q  <= maxx_d;
                        miny_q  <= miny_d;
                        maxy_q  <= maxy_d;
                        if (last_px) begin
                            if (found_d) begin
                                xs_q    <= minx_d;
                                xe_q    <= maxx_d;
                                ys_q    <= miny_d;
                                ye_q    <= maxy_d;
                                state_q <= S_CROP;
                            end else begin
                                done_q  <= 1'b1;
                                nf_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_CROP: begin
                    if (iDVAL && in_win) begin
                        odval_q <= 1'b1;
                        odata_q <= iDATA;
                        ox_q    <= x_q;
                        oy_q    <= y_q;
                    end
                    if (last_px) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oNOTFOUND = nf_q;
    assign oXSTART   = xs_q;
    assign oXEND     = xe_q;
    assign oYSTART   = ys_q;
    assign oYEND     = ye_q;
    assign oDVAL     = odval_q;
    assign oDATA     = odata_q;
    assign oX_Cont   = ox_q;
    assign oY_Cont   = oy_q;

endmodule

// File: tb/tb_crop_frame_ctrl.sv
// tb_crop_frame_ctrl
//   Directed + randomized bench for crop_frame_ctrl on an 8x4 frame. The
//   reference is a plain image array: the expected box is a scan for pixels
//   at or above the threshold, and the expected crop output is the raster
//   list of pixels inside that box.
module tb_crop_frame_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NP = H * V;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iSTART = 1'b0;
    logic [9:0]  iTHRESH = '0;
    logic        iDVAL = 1'b0;
    logic [9:0]  iDATA = '0;
    logic        oBUSY, oDONE, oNOTFOUND, oDVAL;
    logic [15:0] oXSTART, oXEND, oYSTART, oYEND, oX_Cont, oY_Cont;
    logic [9:0]  oDATA;

    crop_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iTHRESH(iTHRESH),
        .iDVAL(iDVAL), .iDATA(iDATA), .oBUSY(oBUSY), .oDONE(oDONE),
        .oNOTFOUND(oNOTFOUND), .oXSTART(oXSTART), .oXEND(oXEND),
        .oYSTART(oYSTART), .oYEND(oYEND), .oDVAL(oDVAL), .oDATA(oDATA),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc++;

    typedef struct { int x; int y; int d; } pix_t;
    pix_t got[$];
    int done_cnt = 0, done_cyc = -1, done_nf = 0, done_busy = 0, nf_stray = 0;

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge iCLK) begin
        #1;
        if (oDVAL) got.push_back('{int'(oX_Cont), int'(oY_Cont), int'(oDATA)});
        if (oDONE) begin
            done_cnt++;
            done_cyc  = cyc;
            done_nf   = int'(oNOTFOUND);
            done_busy = int'(oBUSY);
        end
        if (oNOTFOUND && !oDONE) nf_stray++;
    end

    int nchk = 0, nerr = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [9:0] img[NP];
    logic [9:0] cimg[NP];
    int pos = 0;         // raster index the next beat lands on
    int last_cyc = 0;    // cycle count when the latest beat was driven
    int gap_pct = 0;
    int pxs = 0, pxe = 0, pys = 0, pye = 0;  // box the DUT should hold now

    task automatic beat(input logic [9:0] d, input bit st);
        for (int g = 0; g < 20 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
            @(negedge iCLK);
            iDVAL = 1'b0; iSTART = 1'b0;
        end
        @(negedge iCLK);
        iDVAL = 1'b1; iDATA = d; iSTART = st;
        if (st) iTHRESH = 10'd0;
        last_cyc = cyc;
        pos = (pos + 1) % NP;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            iDVAL = 1'b0; iSTART = 1'b0;
        end
    endtask

    // One start -> ARM -> MEASURE [-> CROP] sequence against img/cimg.
    // inject: measure-frame index where a busy iSTART is issued (-1 none).
    // abort:  crop-frame index where a 1-cycle reset is applied (-1 none).
    // post:   issue iSTART during the oDONE cycle.
    task automatic run_seq(input string tag, input logic [9:0] th,
                           input int inject, input int abort, input bit post);
        int mnx, mxx, mny, mxy, meas_last, crop_last, ex_done;
        bit found;
        pix_t exp_q[$];
        mnx = H; mxx = -1; mny = V; mxy = -1; found = 0;
        for (int p = 0; p < NP; p++)
            if (img[p] >= th) begin
                found = 1;
                if (p % H < mnx) mnx = p % H;
                if (p % H > mxx) mxx = p % H;
                if (p / H < mny) mny = p / H;
                if (p / H > mxy) mxy = p / H;
            end
        got.delete(); done_cnt = 0; done_cyc = -1; crop_last = 0;

        @(negedge iCLK);
        iSTART = 1'b1; iTHRESH = th; iDVAL = 1'b0;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        chk({tag, " busy_rise"}, int'(oBUSY), 1);

        while (pos != 0) beat(10'($urandom_range(1023)), 1'b0);
        for (int p = 0; p < NP; p++) beat(img[p], p == inject);
        meas_last = last_cyc;
        if (found) begin
            for (int p = 0; p < NP; p++) begin
                if (p == abort) begin
                    @(negedge iCLK);
                    iRST = 1'b0; iDVAL = 1'b0;
                    #1;
                    chk({tag, " rst_dval"}, int'(oDVAL), 0);
                    chk({tag, " rst_busy"}, int'(oBUSY), 0);
                    chk({tag, " rst_box"}, int'(oXSTART | oXEND | oYSTART | oYEND), 0);
                    @(negedge iCLK);
                    iRST = 1'b1;
                    pos = 0; pxs = 0; pxe = 0; pys = 0; pye = 0;
                    idle(2);
                    return;
                end
                beat(cimg[p], 1'b0);
            end
            crop_last = last_cyc;
        end
        if (post) begin
            @(negedge iCLK);
            iDVAL = 1'b0; iSTART = 1'b1; iTHRESH = 10'd0;
        end
        idle(3);

        ex_done = (found ? crop_last : meas_last) + 1;
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " done_cyc"}, done_cyc, ex_done);
        chk({tag, " notfound"}, done_nf, found ? 0 : 1);
        chk({tag, " busy_at_done"}, done_busy, 0);
        chk({tag, " busy_after"}, int'(oBUSY), 0);
        if (found) begin
            pxs = mnx; pxe = mxx; pys = mny; pye = mxy;
        end
        chk({tag, " xstart"}, int'(oXSTART), pxs);
        chk({tag, " xend"}, int'(oXEND), pxe);
        chk({tag, " ystart"}, int'(oYSTART), pys);
        chk({tag, " yend"}, int'(oYEND), pye);
        if (found)
            for (int p = 0; p < NP; p++)
                if (p % H >= mnx && p % H <= mxx && p / H >= mny && p / H <= mxy)
                    exp_q.push_back('{p % H, p / H, int'(cimg[p])});
        chk({tag, " dval_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s px%0d_x", tag, i), got[i].x, exp_q[i].x);
            chk($sformatf("%s px%0d_y", tag, i), got[i].y, exp_q[i].y);
            chk($sformatf("%s px%0d_d", tag, i), got[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        // Reset held with the stream toggling.
        for (int i = 0; i < 8; i++) begin
            @(negedge iCLK);
            iDVAL = i[0]; iDATA = 10'(i * 100); iSTART = i[1];
            #2;
            if (i % 3 == 0) begin
                chk("rst outs", int'({oBUSY, oDONE, oNOTFOUND, oDVAL}), 0);
                chk("rst data", int'(oDATA | oX_Cont | oY_Cont), 0);
                chk("rst box", int'(oXSTART | oXEND | oYSTART | oYEND), 0);
                chk("rst cnt", int'(dut.x_q | dut.y_q), 0);
            end
        end
        @(negedge iCLK);
        iDVAL = 1'b0; iSTART = 1'b0; iRST = 1'b1;
        idle(2);
        chk("cnt hold", int'(dut.x_q), 0);
        gap_pct = 50;
        for (int i = 0; i < 3; i++) beat(10'd0, 1'b0);
        idle(1);
        chk("cnt step", int'(dut.x_q), 3);
        gap_pct = 0;

        // Single bright pixel; iSTART during the oDONE cycle is dropped.
        for (int p = 0; p < NP; p++) img[p] = 10'd100;
        img[2 * H + 3] = 10'd900;
        for (int p = 0; p < NP; p++) cimg[p] = img[p];
        run_seq("single", 10'd512, -1, -1, 1'b1);

        // Rectangle at exactly the threshold.
        for (int p = 0; p < NP; p++)
            img[p] = (p % H >= 2 && p % H <= 5 && p / H >= 1 && p / H <= 2) ? 10'd512 : 10'd100;
        for (int p = 0; p < NP; p++) cimg[p] = img[p];
        run_seq("rect", 10'd512, -1, -1, 1'b0);

        // Nothing qualifies: box keeps the rectangle.
        for (int p = 0; p < NP; p++) img[p] = 10'd10;
        run_seq("none", 10'd512, -1, -1, 1'b0);

        // 50% gaps, start issued at (4,1), fresh crop data.
        gap_pct = 50;
        while (pos != 12) beat(10'($urandom_range(1023)), 1'b0);
        for (int p = 0; p < NP; p++)
            img[p] = (p % H >= 2 && p % H <= 5 && p / H >= 1 && p / H <= 2) ? 10'd512 : 10'd100;
        for (int p = 0; p < NP; p++) cimg[p] = 10'($urandom_range(1023));
        run_seq("gaps", 10'd512, -1, -1, 1'b0);

        // Random image with a busy iSTART during MEASURE.
        gap_pct = 30;
        for (int p = 0; p < NP; p++) img[p] = 10'($urandom_range(800));
        img[$urandom_range(NP - 1)] = 10'd1000;
        for (int p = 0; p < NP; p++) cimg[p] = 10'($urandom_range(1023));
        run_seq("rand", 10'd900, 10, -1, 1'b0);

        // Reset mid-CROP, then a normal sequence.
        gap_pct = 0;
        run_seq("abort", 10'd900, -1, 12, 1'b0);
        for (int p = 0; p < NP; p++) cimg[p] = 10'($urandom_range(1023));
        run_seq("after_rst", 10'd900, -1, -1, 1'b0);

        chk("nf_stray", nf_stray, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
